// File: rtl/replay_pkg.sv
// Shared constants and state type for the replay-buffer index sampler.
package replay_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int RND_W      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } sampler_state_e;
endpackage

// File: rtl/sample_scale.sv
// Maps a 16-bit random word onto [0, fill) by full-width multiply and shift.
module sample_scale
  import replay_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [RND_W-1:0]  rnd,
  input  logic [ADDR_W:0]   fill,
  output logic [ADDR_W-1:0] idx
);
  localparam int PROD_W = RND_W + ADDR_W + 1;

  logic [PROD_W-1:0] prod;
  logic              unused_prod_msb;

  assign prod = PROD_W'(rnd) * PROD_W'(fill);
  // rnd < 2^16 guarantees the shifted product is below fill, so the top bit is always 0.
  assign idx             = prod[RND_W +: ADDR_W];
  assign unused_prod_msb = prod[PROD_W-1];
endmodule

// File: rtl/replay_sampler.sv
// Draws BATCH uniformly scaled indices into a replay buffer per start request.
module replay_sampler
  import replay_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BATCH  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RND_W-1:0]    rnd,
  input  logic                rnd_vld,
  output logic                rnd_take,
  input  logic                start,
  input  logic [ADDR_W:0]     fill_count,
  output logic [ADDR_W-1:0]   idx,
  output logic                idx_vld,
  input  logic                idx_rdy,
  output logic                idx_last,
  output logic                busy,
  output logic                done,
  output logic                err,
  output sampler_state_e      dbg_state
);
  localparam logic [15:0] BATCH_C = 16'(BATCH);

  // Handshakes: a word moves only when valid && ready (rnd_vld && rnd_take,
  // idx_vld && idx_rdy); the producer holds its payload stable until then.

  sampler_state_e    state_q, state_d;
  logic [15:0]       issued_q, issued_d;
  logic [ADDR_W:0]   fill_snap_q, fill_snap_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              idx_vld_q, idx_vld_d;
  logic              idx_last_q, idx_last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              consume;
  logic [15:0]       issued_inc;
  logic [ADDR_W-1:0] scaled;

  sample_scale #(.ADDR_W(ADDR_W)) u_scale (
    .rnd  (rnd),
    .fill (fill_snap_q),
    .idx  (scaled)
  );

  always_comb begin
    rnd_take    = (state_q == RUN) && (issued_q < BATCH_C) && (!idx_vld_q || idx_rdy);
    consume     = rnd_take && rnd_vld;
    issued_inc  = issued_q + 16'd1;
    state_d     = state_q;
    issued_d    = issued_q;
    fill_snap_d = fill_snap_q;
    idx_d       = idx_q;
    idx_vld_d   = idx_vld_q;
    idx_last_d  = idx_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (fill_count != '0) begin
            fill_snap_d = fill_count;
            issued_d    = 16'd0;
            state_d     = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        // Leave as the last word is taken so FLUSH can see that index accepted.
        if (consume && (issued_inc == BATCH_C)) state_d = FLUSH;
      end
      FLUSH: begin
        if (idx_vld_q && idx_last_q && idx_rdy) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (consume) begin
      issued_d   = issued_inc;
      idx_d      = scaled;
      idx_vld_d  = 1'b1;
      idx_last_d = (issued_inc == BATCH_C);
    end else if (idx_vld_q && idx_rdy) begin
      idx_vld_d  = 1'b0;
      idx_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      issued_q    <= 16'd0;
      fill_snap_q <= '0;
      idx_q       <= '0;
      idx_vld_q   <= 1'b0;
      idx_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      fill_snap_q <= fill_snap_d;
      idx_q       <= idx_d;
      idx_vld_q   <= idx_vld_d;
      idx_last_q  <= idx_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign idx       = idx_q;
  assign idx_vld   = idx_vld_q;
  assign idx_last  = idx_last_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_replay_sampler.sv
// Bench for replay_sampler: vector table of scaled indices plus multi-cycle corner sequences.
module tb_replay_sampler;
  import replay_pkg::*;

  localparam int AW = 10;
  localparam int BT = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [15:0]    rnd = 16'd0;
  logic           rnd_vld = 1'b0;
  logic           rnd_take;
  logic           start = 1'b0;
  logic [AW:0]    fill_count = '0;
  logic [AW-1:0]  idx;
  logic           idx_vld;
  logic           idx_rdy = 1'b1;
  logic           idx_last;
  logic           busy;
  logic           done;
  logic           err;
  sampler_state_e dbg_state;

  replay_sampler #(.ADDR_W(AW), .BATCH(BT)) dut (
    .clk        (clk),
    .rst        (rst),
    .rnd        (rnd),
    .rnd_vld    (rnd_vld),
    .rnd_take   (rnd_take),
    .start      (start),
    .fill_count (fill_count),
    .idx        (idx),
    .idx_vld    (idx_vld),
    .idx_rdy    (idx_rdy),
    .idx_last   (idx_last),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]   rnd;
    logic [AW:0]   fill;
    logic [AW-1:0] exp_idx;
  } vec_t;

  vec_t          vecs[16];
  logic [AW:0]   exp_q[$];      // {last, idx}
  logic [15:0]   rnd_src[$];
  int            acc_cyc[$];
  bit            gap_mode = 1'b0;
  bit            gap_ph = 1'b0;
  bit            consumed = 1'b0;
  bit            prev_hold = 1'b0;
  logic [AW-1:0] prev_idx = '0;
  logic [AW:0]   mon_e;
  int            checks = 0;
  int            errors = 0;
  int            n_take = 0;
  int            n_done = 0;
  int            n_acc = 0;
  int            cyc = 0;
  int            done_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (prev_hold) begin
        chk("hold_idx", 32'(idx), 32'(prev_idx));
        chk("hold_vld", 32'(idx_vld), 32'd1);
      end
      prev_hold = idx_vld && !idx_rdy;
      prev_idx  = idx;
      consumed  = rnd_vld && rnd_take;
      if (consumed) n_take++;
      if (idx_vld && idx_rdy) begin
        n_acc++;
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_idx", 32'(idx), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("idx", 32'(idx), 32'(mon_e[AW-1:0]));
          chk("idx_last", 32'(idx_last), 32'(mon_e[AW]));
        end
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end else begin
      prev_hold = 1'b0;
      consumed  = 1'b0;
    end
  end

  // random-word driver: presents the head of rnd_src, pops it once consumed
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (consumed && rnd_src.size() > 0) void'(rnd_src.pop_front());
      gap_ph = ~gap_ph;
      if (rnd_src.size() > 0 && (!gap_mode || gap_ph)) begin
        rnd_vld = 1'b1;
        rnd     = rnd_src[0];
      end else begin
        rnd_vld = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_group(input int g);
    for (int i = 0; i < BT; i++) begin
      rnd_src.push_back(vecs[g*BT+i].rnd);
      exp_q.push_back({(i == BT-1) ? 1'b1 : 1'b0, vecs[g*BT+i].exp_idx});
    end
  endtask

  task automatic pulse_start(input logic [AW:0] fill);
    fill_count = fill;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_batch(input int budget);
    int d0;
    d0 = n_done;
    for (int k = 0; k < budget; k++) begin
      step();
      if (n_done != d0) break;
    end
    chk("done_seen", 32'(n_done - d0), 32'd1);
  endtask

  task automatic wait_acc(input int n, input int budget);
    int a0;
    a0 = n_acc;
    for (int k = 0; k < budget; k++) begin
      if (n_acc - a0 >= n) break;
      step();
    end
    chk("acc_reached", 32'(n_acc - a0 >= n), 32'd1);
  endtask

  task automatic run_group(input int g);
    int t0;
    load_group(g);
    step();
    t0 = n_take;
    acc_cyc.delete();
    pulse_start(vecs[g*BT].fill);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_batch(40);
    chk("takes", 32'(n_take - t0), BT);
    chk("exp_empty", 32'(exp_q.size()), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{16'h0000, 11'd100,  10'd0};
    vecs[1]  = '{16'h8000, 11'd100,  10'd50};
    vecs[2]  = '{16'hFFFF, 11'd100,  10'd99};
    vecs[3]  = '{16'h4000, 11'd100,  10'd25};
    vecs[4]  = '{16'hFFFF, 11'd1024, 10'd1023};
    vecs[5]  = '{16'h0001, 11'd1024, 10'd0};
    vecs[6]  = '{16'h8000, 11'd1024, 10'd512};
    vecs[7]  = '{16'hC000, 11'd1024, 10'd768};
    vecs[8]  = '{16'hFFFF, 11'd1,    10'd0};
    vecs[9]  = '{16'h1234, 11'd1,    10'd0};
    vecs[10] = '{16'h8000, 11'd1,    10'd0};
    vecs[11] = '{16'h0000, 11'd1,    10'd0};
    vecs[12] = '{16'h9249, 11'd7,    10'd3};
    vecs[13] = '{16'hFFFF, 11'd7,    10'd6};
    vecs[14] = '{16'h2000, 11'd7,    10'd0};
    vecs[15] = '{16'h2493, 11'd7,    10'd1};

    // reset state
    repeat (3) step();
    chk("rst_idx_vld", 32'(idx_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rnd_take", 32'(rnd_take), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;
    step();

    // table-driven batches
    for (int g = 0; g < 4; g++) begin
      run_group(g);
      if (g == 0) begin
        chk("acc_count", 32'(acc_cyc.size()), BT);
        for (int i = 1; i < acc_cyc.size(); i++)
          chk("acc_back_to_back", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd1);
        if (acc_cyc.size() > 0)
          chk("done_after_last", 32'(done_cyc - acc_cyc[acc_cyc.size()-1]), 32'd1);
      end
      step();
    end

    // consumer stall after the first index
    begin
      int t0;
      idx_rdy = 1'b0;
      load_group(0);
      step();
      t0 = n_take;
      pulse_start(11'd100);
      for (int k = 0; k < 20; k++) begin
        if (idx_vld) break;
        step();
      end
      chk("stall_first_vld", 32'(idx_vld), 32'd1);
      for (int k = 0; k < 3; k++) begin
        chk("stall_idx", 32'(idx), 32'd0);
        chk("stall_take", 32'(rnd_take), 32'd0);
        chk("stall_consumed", 32'(n_take - t0), 32'd1);
        step();
      end
      idx_rdy = 1'b1;
      wait_batch(40);
      chk("stall_takes", 32'(n_take - t0), BT);
      chk("stall_exp_empty", 32'(exp_q.size()), 32'd0);
      step();
    end

    // start with an empty buffer
    fill_count = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_idx_vld", 32'(idx_vld), 32'd0);
    chk("err_take", 32'(rnd_take), 32'd0);
    step();
    chk("err_one_cycle", 32'(err), 32'd0);
    chk("err_busy2", 32'(busy), 32'd0);

    // fill_count change mid-batch must not affect scaling
    load_group(0);
    step();
    pulse_start(11'd100);
    wait_acc(2, 40);
    fill_count = 11'd10;
    wait_batch(40);
    chk("fillchg_exp_empty", 32'(exp_q.size()), 32'd0);
    step();

    // rnd_vld toggling every cycle
    begin
      int t0, d0;
      gap_mode = 1'b1;
      load_group(3);
      step();
      t0 = n_take;
      d0 = n_done;
      pulse_start(11'd7);
      wait_batch(60);
      repeat (6) step();
      chk("gap_takes", 32'(n_take - t0), BT);
      chk("gap_dones", 32'(n_done - d0), 32'd1);
      chk("gap_exp_empty", 32'(exp_q.size()), 32'd0);
      gap_mode = 1'b0;
    end

    // reset mid-batch, then a clean batch
    load_group(1);
    step();
    pulse_start(11'd1024);
    wait_acc(2, 40);
    #2 rst = 1'b0;
    #1;
    chk("mrst_idx_vld", 32'(idx_vld), 32'd0);
    chk("mrst_idx", 32'(idx), 32'd0);
    chk("mrst_last", 32'(idx_last), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_err", 32'(err), 32'd0);
    chk("mrst_take", 32'(rnd_take), 32'd0);
    chk("mrst_state", 32'(dbg_state), 32'(IDLE));
    exp_q.delete();
    rnd_src.delete();
    repeat (2) step();
    rst = 1'b1;
    step();
    run_group(0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
